// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_TABLE [8] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000   // 7
  };

  typedef struct packed {
    logic       en;
    logic [2:0] data;
  } digit_t;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/bcd7seg.sv
// Shared 3-bit digit to active-low segment decoder; blank when disabled.
module bcd7seg
  import seg_pkg::*;
(
  input  logic [2:0] b,
  input  logic       en,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (en) seg = SEG_TABLE[b];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIG        = 4,
  parameter int SCAN_DIV     = 4,
  parameter int BLANK_CYC    = 1,
  parameter int BLINK_FRAMES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(N_DIG)-1:0] wr_idx,
  input  logic [2:0]               wr_data,
  input  logic                     wr_en,
  input  logic                     commit_i,
  input  logic [N_DIG-1:0]         blink_mask,
  output logic [6:0]               seg_o,
  output logic [N_DIG-1:0]         an_o,
  output logic                     frame_o
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIG);
  localparam int BW = $clog2(BLINK_FRAMES) + 1;

  localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PBLK  = PW'(BLANK_CYC);
  localparam logic [IW-1:0] ILAST = IW'(N_DIG - 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]    presc, presc_n;
  logic [IW-1:0]    idx, idx_n;
  state_t           state, state_n;
  logic             slot_end, boundary;

  digit_t           shadow [N_DIG];
  digit_t           active [N_DIG];
  logic             pending;

  logic [BW-1:0]    bcnt;
  logic             blink_off;

  logic             dec_en;
  logic [6:0]       dec_seg;
  logic [N_DIG-1:0] an_n;

  // Outputs are registered from the next-cycle scan position so that the
  // visible seg/an pins line up with the prescaler slot they belong to.
  always_comb begin
    slot_end = (presc == PLAST);
    boundary = slot_end && (idx == ILAST);
    presc_n  = slot_end ? '0 : presc + 1'b1;
    idx_n    = idx;
    if (slot_end) idx_n = (idx == ILAST) ? '0 : idx + 1'b1;
    state_n  = state;
    if (slot_end)              state_n = ST_BLANK;
    else if (presc_n == PBLK)  state_n = ST_DRIVE;
    dec_en   = (state_n == ST_DRIVE) && active[idx_n].en &&
               !(blink_off && blink_mask[idx_n]);
    an_n     = '1;
    if (state_n == ST_DRIVE) an_n[idx_n] = 1'b0;
    wr_ready = ~pending;
  end

  bcd7seg u_dec (
    .b   (active[idx_n].data),
    .en  (dec_en),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
      state <= ST_BLANK;
    end else begin
      presc <= presc_n;
      idx   <= idx_n;
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_o   <= SEG_OFF;
      an_o    <= '1;
      frame_o <= 1'b0;
    end else begin
      seg_o   <= dec_seg;
      an_o    <= an_n;
      frame_o <= boundary;
    end
  end

  // A commit seen while pending is ignored; a pending commit only lands on a
  // frame boundary, so a commit raised in the boundary cycle waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_DIG; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pending <= 1'b0;
    end else begin
      if (wr_valid && wr_ready && (int'(wr_idx) < N_DIG))
        shadow[wr_idx] <= {wr_en, wr_data};
      if (pending) begin
        if (boundary) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end else if (commit_i) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt      <= '0;
      blink_off <= 1'b0;
    end else if (boundary) begin
      if (bcnt == BLAST) begin
        bcnt      <= '0;
        blink_off <= ~blink_off;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (N_DIG=4, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2).
module tb_seg_scan_ctrl;

  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S7  = 7'b1111000;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_idx;
  logic [2:0] wr_data;
  logic       wr_en;
  logic       commit_i;
  logic [3:0] blink_mask;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic       frame_o;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int         c0;
    int         c1;
    bit         ld;
    logic       wv;
    logic [1:0] widx;
    logic [2:0] wdat;
    logic       wen;
    logic       cmt;
    logic [3:0] bm;
    bit         ck;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frm;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  seg_scan_ctrl #(
    .N_DIG       (4),
    .SCAN_DIV    (4),
    .BLANK_CYC   (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .commit_i  (commit_i),
    .blink_mask(blink_mask),
    .seg_o     (seg_o),
    .an_o      (an_o),
    .frame_o   (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t ldv(int c, logic wv, logic [1:0] widx, logic [2:0] wdat,
                               logic wen, logic cmt, logic [3:0] bm);
    vec_t v;
    v = '{c0: c, c1: c, ld: 1'b1, wv: wv, widx: widx, wdat: wdat, wen: wen, cmt: cmt,
          bm: bm, ck: 1'b0, an: '1, seg: OFF, frm: 1'b0, rdy: 1'b1};
    return v;
  endfunction

  function automatic vec_t ckv(int c0, int c1, logic [3:0] an, logic [6:0] seg,
                               logic frm, logic rdy);
    vec_t v;
    v = '{c0: c0, c1: c1, ld: 1'b0, wv: 1'b0, widx: '0, wdat: '0, wen: 1'b0, cmt: 1'b0,
          bm: '0, ck: 1'b1, an: an, seg: seg, frm: frm, rdy: rdy};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input int c, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, c, act, exp);
    end
  endtask

  task automatic check_outs(input int c, input logic [3:0] an, input logic [6:0] seg,
                            input logic frm, input logic rdy);
    chk("an_o",     c, {4'b0, an_o},     {4'b0, an});
    chk("seg_o",    c, {1'b0, seg_o},    {1'b0, seg});
    chk("frame_o",  c, {7'b0, frame_o},  {7'b0, frm});
    chk("wr_ready", c, {7'b0, wr_ready}, {7'b0, rdy});
  endtask

  function automatic logic [3:0] idle_an(int c);
    logic [3:0] r;
    r = '1;
    if (c % 4 != 0) r[(c / 4) % 4] = 1'b0;
    return r;
  endfunction

  initial begin
    rst        = 1'b1;
    wr_valid   = 1'b0;
    wr_idx     = '0;
    wr_data    = '0;
    wr_en      = 1'b0;
    commit_i   = 1'b0;
    blink_mask = '0;

    vecs.push_back(ldv(32, 1, 2, 3, 1, 0, 4'b0000));
    vecs.push_back(ckv(32, 32, 4'b1111, OFF, 1, 1));
    vecs.push_back(ckv(33, 33, 4'b1110, OFF, 0, 1));
    vecs.push_back(ldv(33, 0, 0, 0, 0, 1, 4'b0000));
    vecs.push_back(ckv(34, 35, 4'b1110, OFF, 0, 0));
    vecs.push_back(ldv(34, 1, 1, 5, 1, 0, 4'b0000));
    vecs.push_back(ckv(36, 36, 4'b1111, OFF, 0, 0));
    vecs.push_back(ckv(37, 39, 4'b1101, OFF, 0, 0));
    vecs.push_back(ckv(40, 40, 4'b1111, OFF, 0, 0));
    vecs.push_back(ckv(41, 43, 4'b1011, OFF, 0, 0));
    vecs.push_back(ckv(44, 44, 4'b1111, OFF, 0, 0));
    vecs.push_back(ckv(45, 47, 4'b0111, OFF, 0, 0));
    vecs.push_back(ckv(48, 48, 4'b1111, OFF, 1, 1));
    vecs.push_back(ckv(49, 49, 4'b1110, OFF, 0, 1));
    vecs.push_back(ldv(49, 1, 0, 7, 1, 1, 4'b0000));
    vecs.push_back(ckv(50, 51, 4'b1110, OFF, 0, 0));
    vecs.push_back(ldv(50, 0, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(ckv(53, 55, 4'b1101, OFF, 0, 0));
    vecs.push_back(ckv(57, 59, 4'b1011, S3,  0, 0));
    vecs.push_back(ckv(61, 63, 4'b0111, OFF, 0, 0));
    vecs.push_back(ckv(64, 64, 4'b1111, OFF, 1, 1));
    vecs.push_back(ckv(65, 66, 4'b1110, S7,  0, 1));
    vecs.push_back(ldv(66, 1, 0, 0, 1, 1, 4'b0000));
    vecs.push_back(ckv(67, 67, 4'b1110, S7,  0, 0));
    vecs.push_back(ldv(67, 0, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(ckv(69, 71, 4'b1101, S5,  0, 0));
    vecs.push_back(ckv(73, 75, 4'b1011, S3,  0, 0));
    vecs.push_back(ckv(77, 79, 4'b0111, OFF, 0, 0));
    vecs.push_back(ckv(80, 80, 4'b1111, OFF, 1, 1));
    vecs.push_back(ldv(80, 0, 0, 0, 0, 0, 4'b0001));
    vecs.push_back(ckv(81, 83, 4'b1110, S0,  0, 1));
    vecs.push_back(ckv(85, 87, 4'b1101, S5,  0, 1));
    vecs.push_back(ckv(96, 96, 4'b1111, OFF, 1, 1));
    vecs.push_back(ckv(97, 99, 4'b1110, OFF, 0, 1));
    vecs.push_back(ckv(101, 103, 4'b1101, S5, 0, 1));
    vecs.push_back(ckv(105, 105, 4'b1011, S3, 0, 1));
    vecs.push_back(ckv(113, 115, 4'b1110, OFF, 0, 1));
    vecs.push_back(ckv(128, 128, 4'b1111, OFF, 1, 1));
    vecs.push_back(ckv(129, 130, 4'b1110, S0, 0, 1));
    vecs.push_back(ldv(130, 1, 3, 1, 1, 1, 4'b0001));
    vecs.push_back(ckv(131, 131, 4'b1110, S0, 0, 0));
    vecs.push_back(ldv(131, 0, 0, 0, 0, 0, 4'b0001));
    vecs.push_back(ckv(133, 133, 4'b1101, S5, 0, 0));

    repeat (3) step();
    rst = 1'b0;
    cyc = 0;
    check_outs(0, 4'b1111, OFF, 1'b0, 1'b1);

    for (int c = 1; c <= 31; c++) begin
      step();
      check_outs(c, idle_an(c), OFF, (c % 16 == 0), 1'b1);
    end

    for (int c = 32; c <= 133; c++) begin
      step();
      for (int k = 0; k < vecs.size(); k++)
        if (vecs[k].ck && c >= vecs[k].c0 && c <= vecs[k].c1)
          check_outs(c, vecs[k].an, vecs[k].seg, vecs[k].frm, vecs[k].rdy);
      for (int k = 0; k < vecs.size(); k++)
        if (vecs[k].ld && c == vecs[k].c0) begin
          wr_valid   = vecs[k].wv;
          wr_idx     = vecs[k].widx;
          wr_data    = vecs[k].wdat;
          wr_en      = vecs[k].wen;
          commit_i   = vecs[k].cmt;
          blink_mask = vecs[k].bm;
        end
    end

    // Reset mid-DRIVE with a commit pending: everything returns to idle.
    rst = 1'b1;
    step();
    check_outs(-1, 4'b1111, OFF, 1'b0, 1'b1);
    rst        = 1'b0;
    blink_mask = '0;
    commit_i   = 1'b1;
    cyc        = 0;
    step();
    commit_i = 1'b0;
    check_outs(1, idle_an(1), OFF, 1'b0, 1'b0);
    // Commit of the cleared shadow must keep every digit blank.
    for (int c = 2; c <= 31; c++) begin
      step();
      check_outs(c, idle_an(c), OFF, (c % 16 == 0), (c >= 16));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
